systolic_ctrl: RTL

Sequencer for the ROWS x COLS systolic array of `PE` cells. On a `start` pulse it optionally streams a weight tile from the weight buffer into the array using the `weight_wren` shift path. It then streams `num_vectors` activation vectors with `active` asserted and captures results into the accumulator buffer after the array pipeline latency. It sits between the host command interface and the array/buffer datapath and owns all array-level enables.

---
 rtl/systolic_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/systolic_ctrl.sv
// Job sequencer for a ROWS x COLS systolic array: optional weight-tile load,
// activation streaming, and result capture after the array pipeline latency.
module systolic_ctrl #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int PIPE_LAT = ROWS + COLS - 1,
  parameter int AW       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    load_weights,
  input  logic [AW-1:0]           num_vectors,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    w_rd_en,
  output logic [$clog2(ROWS)-1:0] w_rd_addr,
  output logic                    weight_wren,
  output logic                    a_rd_en,
  output logic [AW-1:0]           a_rd_addr,
  output logic                    active,
  output logic                    acc_wr_en,
  output logic [AW-1:0]           acc_wr_addr
);

  localparam int RW = $clog2(ROWS);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WLOAD   = 3'd1;
  localparam logic [2:0] WSETTLE = 3'd2;
  localparam logic [2:0] COMPUTE = 3'd3;
  localparam logic [2:0] DRAIN   = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  localparam logic [RW-1:0] WADDR_TOP = RW'(ROWS - 1);

  logic [2:0]          state_q, state_d;
  logic [RW-1:0]       waddr_q, waddr_d;
  logic [AW-1:0]       aaddr_q, aaddr_d;
  logic [AW-1:0]       accaddr_q, accaddr_d;
  logic [AW-1:0]       m_q, m_d;
  logic [AW-1:0]       m_last;
  logic                wwren_q;
  logic                active_q;
  logic [PIPE_LAT-1:0] accsr_q;
  logic                flush;
  logic                last_write;

  // Terminal compares use M-1 so that M = 2^AW-1 never needs a wider counter.
  assign m_last     = m_q - AW'(1);
  assign flush      = abort && (state_q != IDLE);
  assign last_write = acc_wr_en && (accaddr_q == m_last);

  always_comb begin
    state_d   = state_q;
    waddr_d   = waddr_q;
    aaddr_d   = aaddr_q;
    accaddr_d = accaddr_q;
    m_d       = m_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          m_d       = num_vectors;
          aaddr_d   = '0;
          accaddr_d = '0;
          if (load_weights) begin
            state_d = WLOAD;
            waddr_d = WADDR_TOP;
          end else if (num_vectors != '0) begin
            state_d = COMPUTE;
          end else begin
            state_d = DONE;
          end
        end
      end
      WLOAD: begin
        if (waddr_q == '0) state_d = WSETTLE;
        else               waddr_d = waddr_q - RW'(1);
      end
      WSETTLE: state_d = (m_q != '0) ? COMPUTE : DONE;
      COMPUTE: begin
        if (aaddr_q == m_last) begin
          state_d = DRAIN;
          aaddr_d = '0;
        end else begin
          aaddr_d = aaddr_q + AW'(1);
        end
      end
      DRAIN:   if (last_write) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (acc_wr_en) accaddr_d = last_write ? '0 : accaddr_q + AW'(1);

    // Abort wins over everything except an IDLE start, which never sees flush.
    if (flush) begin
      state_d   = IDLE;
      waddr_d   = '0;
      aaddr_d   = '0;
      accaddr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      waddr_q   <= '0;
      aaddr_q   <= '0;
      accaddr_q <= '0;
      m_q       <= '0;
      wwren_q   <= 1'b0;
      active_q  <= 1'b0;
      accsr_q   <= '0;
    end else begin
      state_q   <= state_d;
      waddr_q   <= waddr_d;
      aaddr_q   <= aaddr_d;
      accaddr_q <= accaddr_d;
      m_q       <= m_d;
      wwren_q   <= flush ? 1'b0 : w_rd_en;
      active_q  <= flush ? 1'b0 : a_rd_en;
      accsr_q   <= flush ? '0 : ((accsr_q << 1) | PIPE_LAT'(active_q));
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign w_rd_en     = (state_q == WLOAD);
  assign w_rd_addr   = waddr_q;
  assign weight_wren = wwren_q;
  assign a_rd_en     = (state_q == COMPUTE);
  assign a_rd_addr   = aaddr_q;
  assign active      = active_q;
  assign acc_wr_en   = accsr_q[PIPE_LAT-1];
  assign acc_wr_addr = accaddr_q;

endmodule
